// File: rtl/bcd_xs3_codec_seq.sv
// Serial multi-digit BCD <-> Excess-3 converter. It converts one digit per clock, least-significant digit first.
// Each result word carries a per-digit error mask for digits that are invalid in the selected mode.
module bcd_xs3_codec_seq #(
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [4*NDIGITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   out_data,
    output logic [NDIGITS-1:0]     out_err_mask,
    output logic                   out_err,
    output logic [1:0]             state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Valid does not depend on ready. in_ready is high only in IDLE; out_valid is high only in HOLD.

    localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(NDIGITS - 1);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [4*NDIGITS-1:0] cap_data;
    logic                 cap_mode;
    logic [3:0]           cur_digit;
    logic [3:0]           cur_result;
    logic                 cur_invalid;

    always_comb begin
        cur_digit = cap_data[3:0];
        for (int i = 0; i < NDIGITS; i++) begin
            if (cnt == CW'(i)) cur_digit = cap_data[4*i +: 4];
        end
    end

    // The 4-bit add/subtract wraps by design; invalid digits are forced to 4'hF below.
    always_comb begin
        if (!cap_mode) begin
            cur_invalid = (cur_digit > 4'd9);
            cur_result  = cur_digit + 4'd3;
        end else begin
            cur_invalid = (cur_digit < 4'd3) || (cur_digit > 4'd12);
            cur_result  = cur_digit - 4'd3;
        end
        if (cur_invalid) cur_result = 4'hF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_data     <= '0;
            cap_mode     <= 1'b0;
            out_data     <= '0;
            out_err_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_data     <= in_data;
                        cap_mode     <= in_mode;
                        out_data     <= '0;
                        out_err_mask <= '0;
                        cnt          <= '0;
                        state        <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < NDIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            out_data[4*i +: 4] <= cur_result;
                            out_err_mask[i]    <= cur_invalid;
                        end
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign out_err   = |out_err_mask;
    assign state_dbg = state;

endmodule

// File: tb/tb_bcd_xs3_codec_seq.sv
// Bench for bcd_xs3_codec_seq: a 4-digit instance driven through directed and random words,
// and a 1-digit instance checked at its boundary cases.
module tb_bcd_xs3_codec_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_err;
    logic [15:0] a_in_data, a_out_data;
    logic [3:0]  a_mask;
    logic [1:0]  a_state;

    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
    logic [3:0]  b_in_data, b_out_data;
    logic [0:0]  b_mask;
    logic [1:0]  b_state;

    bcd_xs3_codec_seq #(.NDIGITS(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err_mask(a_mask), .out_err(a_out_err), .state_dbg(a_state)
    );

    bcd_xs3_codec_seq #(.NDIGITS(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err_mask(b_mask), .out_err(b_out_err), .state_dbg(b_state)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  mask_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {err, result} for one digit.
    function automatic logic [4:0] model_digit(input logic [3:0] d, input logic m);
        if (!m) return (d <= 4'd9) ? {1'b0, d + 4'd3} : 5'h1F;
        return (d >= 4'd3 && d <= 4'd12) ? {1'b0, d - 4'd3} : 5'h1F;
    endfunction

    task automatic push_model(input logic [15:0] d, input logic m);
        logic [15:0] ed;
        logic [3:0]  em;
        logic [4:0]  r;
        for (int i = 0; i < 4; i++) begin
            r = model_digit(d[4*i +: 4], m);
            ed[4*i +: 4] = r[3:0];
            em[i] = r[4];
        end
        exp_q.push_back(ed);
        mask_q.push_back(em);
    endtask

    task automatic push_const(input logic [15:0] ed, input logic [3:0] em);
        exp_q.push_back(ed);
        mask_q.push_back(em);
    endtask

    // Returns just after the accepting edge.
    task automatic send_a(input logic [15:0] d, input logic m);
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_mode  = m;
        for (int t = 0; t < 40 && !a_in_ready; t++) @(negedge clk);
        check("a_accept_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 16'hxxxx;
        a_in_mode  = ~m;
    endtask

    task automatic recv_a(input int hold_cycles);
        int k;
        logic [15:0] ed;
        logic [3:0]  em;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (a_out_valid) break;
        end
        check("a_latency", 64'(k), 64'd5);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL a_scoreboard observed=output expected=empty_queue");
        end else begin
            ed = exp_q.pop_front();
            em = mask_q.pop_front();
            check("a_out_data", 64'(a_out_data), 64'(ed));
            check("a_out_mask", 64'(a_mask), 64'(em));
            check("a_out_err", 64'(a_out_err), 64'(|em));
            check("a_hold_in_ready", 64'(a_in_ready), 64'd0);
            for (int j = 0; j < hold_cycles; j++) begin
                a_in_valid = 1'b1;
                a_in_data  = 16'h1111;
                a_in_mode  = 1'b0;
                @(negedge clk);
                check("a_stall_valid", 64'(a_out_valid), 64'd1);
                check("a_stall_data", 64'(a_out_data), 64'(ed));
                check("a_stall_in_ready", 64'(a_in_ready), 64'd0);
            end
            a_in_valid = 1'b0;
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        a_out_ready = 1'b0;
        @(negedge clk);
        check("a_release_valid", 64'(a_out_valid), 64'd0);
        check("a_release_in_ready", 64'(a_in_ready), 64'd1);
        check("a_release_state", 64'(a_state), 64'd0);
    endtask

    task automatic run_b(input logic [3:0] d, input logic m, input logic [3:0] ed, input logic ee);
        int k;
        @(negedge clk);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_mode  = m;
        for (int t = 0; t < 40 && !b_in_ready; t++) @(negedge clk);
        check("b_accept_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = 4'hx;
        k = 0;
        while (k < 40) begin
            @(negedge clk);
            k++;
            if (b_out_valid) break;
        end
        check("b_latency", 64'(k), 64'd2);
        check("b_out_data", 64'(b_out_data), 64'(ed));
        check("b_out_err", 64'(b_out_err), 64'(ee));
        check("b_out_mask", 64'(b_mask), 64'(ee));
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        @(negedge clk);
        check("b_release_in_ready", 64'(b_in_ready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic        rm;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_data", 64'(a_out_data), 64'd0);
        check("rst_a_mask", 64'(a_mask), 64'd0);
        check("rst_a_err", 64'(a_out_err), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_a_state", 64'(a_state), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);

        push_const(16'hC6A3, 4'b0000);
        send_a(16'h9370, 1'b0);
        recv_a(0);

        push_const(16'h9370, 4'b0000);
        send_a(16'hC6A3, 1'b1);
        recv_a(0);

        push_const(16'h45FC, 4'b0010);
        send_a(16'h12F9, 1'b0);
        recv_a(0);

        push_const(16'h0FFF, 4'b0111);
        send_a(16'h3D20, 1'b1);
        recv_a(0);

        push_model(16'h2468, 1'b0);
        send_a(16'h2468, 1'b0);
        recv_a(5);

        // Abort a word mid-conversion; nothing is pushed for it.
        send_a(16'h9999, 1'b0);
        @(negedge clk);
        check("conv_in_ready", 64'(a_in_ready), 64'd0);
        @(negedge clk);
        @(negedge clk);
        check("conv_state", 64'(a_state), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", 64'(a_out_valid), 64'd0);
        check("abort_in_ready", 64'(a_in_ready), 64'd1);
        check("abort_out_data", 64'(a_out_data), 64'd0);
        check("abort_mask", 64'(a_mask), 64'd0);
        check("abort_err", 64'(a_out_err), 64'd0);
        push_const(16'h3333, 4'b0000);
        send_a(16'h0000, 1'b0);
        recv_a(0);

        for (int n = 0; n < 8; n++) begin
            rd = 16'($urandom_range(0, 16'hFFFF));
            rm = 1'($urandom_range(0, 1));
            push_model(rd, rm);
            send_a(rd, rm);
            recv_a(int'($urandom_range(0, 2)));
        end
        check("a_queue_drained", 64'(exp_q.size()), 64'd0);

        run_b(4'h5, 1'b0, 4'h8, 1'b0);
        run_b(4'hA, 1'b0, 4'hF, 1'b1);
        run_b(4'hC, 1'b1, 4'h9, 1'b0);
        run_b(4'h2, 1'b1, 4'hF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
